// File: rtl/find_string_seq_ctrl.sv
// Find_string sequencer: key conditioning, nibble string buffer and match scanner.
// Define FSC_DEBOUNCE_EN to add per-key debouncing (exposes the DEB_CYCLES parameter).
module find_string_seq_ctrl #(
  parameter int DEPTH = 8
`ifdef FSC_DEBOUNCE_EN
  , parameter int DEB_CYCLES = 500000
`endif
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [3:0]                   in_str,
  input  logic [3:0]                   in_comp,
  input  logic                         done,
  input  logic                         submit,
  input  logic                         delete,
  input  logic                         roll_back,
  output logic [$clog2(DEPTH):0]       str_len,
  output logic [3:0]                   last_char,
  output logic                         full,
  output logic                         busy,
  output logic                         result_valid,
  output logic [$clog2(DEPTH):0]       match_cnt,
  output logic                         found,
  output logic [$clog2(DEPTH)-1:0]     first_pos
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {ENTRY, SEARCH, RESULT} state_e;

  // Key bit order: [0] submit, [1] delete, [2] roll_back; all active-low.
  logic [2:0] keyRaw;
  logic [2:0] keySync1_q;
  logic [2:0] keySync2_q;
  logic [2:0] keyLevel;
  logic [2:0] keyHist_q;
  logic [2:0] keyPress;

  assign keyRaw = {roll_back, delete, submit};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      keySync1_q <= '1;
      keySync2_q <= '1;
    end else begin
      keySync1_q <= keyRaw;
      keySync2_q <= keySync1_q;
    end
  end

`ifdef FSC_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [CW-1:0] debCnt_q [3];
  logic [2:0]    debLevel_q;

  // The level only follows the synchronizer after DEB_CYCLES disagreeing samples in a row.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      debLevel_q <= '1;
      for (int k = 0; k < 3; k++) debCnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (keySync2_q[k] == debLevel_q[k]) begin
          debCnt_q[k] <= '0;
        end else if (debCnt_q[k] == CW'(DEB_CYCLES - 1)) begin
          debLevel_q[k] <= keySync2_q[k];
          debCnt_q[k]   <= '0;
        end else begin
          debCnt_q[k] <= debCnt_q[k] + 1'b1;
        end
      end
    end
  end

  assign keyLevel = debLevel_q;
`else
  assign keyLevel = keySync2_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) keyHist_q <= '1;
    else        keyHist_q <= keyLevel;
  end

  assign keyPress = keyHist_q & ~keyLevel;

  logic        subPress;
  logic        delPress;
  logic        rollPress;

  assign subPress  = keyPress[0];
  assign delPress  = keyPress[1];
  assign rollPress = keyPress[2];

  state_e        state_q;
  logic [3:0]    strBuf_q [DEPTH];
  logic [AW:0]   len_q;
  logic [AW-1:0] idx_q;
  logic [3:0]    comp_q;
  logic [AW:0]   match_q;
  logic          found_q;
  logic [AW-1:0] first_q;

  logic [AW:0]   lenMinus1;
  logic          lenFull;
  logic          lenEmpty;

  assign lenMinus1 = len_q - 1'b1;
  assign lenFull   = (len_q == (AW+1)'(DEPTH));
  assign lenEmpty  = (len_q == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ENTRY;
      len_q   <= '0;
      idx_q   <= '0;
      comp_q  <= '0;
      match_q <= '0;
      found_q <= 1'b0;
      first_q <= '0;
      for (int i = 0; i < DEPTH; i++) strBuf_q[i] <= '0;
    end else begin
      case (state_q)
        ENTRY: begin
          // done wins over any key; delete wins over a simultaneous submit.
          if (done) begin
            state_q <= SEARCH;
            comp_q  <= in_comp;
            idx_q   <= '0;
            match_q <= '0;
            found_q <= 1'b0;
            first_q <= '0;
          end else if (rollPress) begin
            len_q <= '0;
          end else if (delPress) begin
            if (!lenEmpty) len_q <= lenMinus1;
          end else if (subPress && !lenFull) begin
            strBuf_q[len_q[AW-1:0]] <= in_str;
            len_q                   <= len_q + 1'b1;
          end
        end

        SEARCH: begin
          if (!lenEmpty && strBuf_q[idx_q] == comp_q) begin
            match_q <= match_q + 1'b1;
            if (!found_q) begin
              found_q <= 1'b1;
              first_q <= idx_q;
            end
          end
          if (lenEmpty || {1'b0, idx_q} == lenMinus1) state_q <= RESULT;
          else                                        idx_q   <= idx_q + 1'b1;
        end

        RESULT: begin
          if (!done) begin
            state_q <= ENTRY;
            match_q <= '0;
            found_q <= 1'b0;
            first_q <= '0;
          end else if (rollPress) begin
            state_q <= SEARCH;
            comp_q  <= in_comp;
            idx_q   <= '0;
            match_q <= '0;
            found_q <= 1'b0;
            first_q <= '0;
          end
        end

        default: state_q <= ENTRY;
      endcase
    end
  end

  assign str_len      = len_q;
  assign last_char    = lenEmpty ? 4'h0 : strBuf_q[lenMinus1[AW-1:0]];
  assign full         = lenFull;
  assign busy         = (state_q == SEARCH);
  assign result_valid = (state_q == RESULT);
  assign match_cnt    = match_q;
  assign found        = found_q;
  assign first_pos    = first_q;

endmodule

// File: tb/tb_find_string_seq_ctrl.sv
// Directed bench for find_string_seq_ctrl: a nibble-queue model predicts each search,
// predictions are queued at launch and checked when result_valid rises.
module tb_find_string_seq_ctrl;

  localparam int DEPTH = 8;
`ifdef FSC_DEBOUNCE_EN
  localparam int HOLD = 12;
`else
  localparam int HOLD = 3;
`endif
  localparam int REL = HOLD + 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in_str;
  logic [3:0] in_comp;
  logic       done;
  logic       submit;
  logic       delete;
  logic       roll_back;
  logic [3:0] str_len;
  logic [3:0] last_char;
  logic       full;
  logic       busy;
  logic       result_valid;
  logic [3:0] match_cnt;
  logic       found;
  logic [2:0] first_pos;

  find_string_seq_ctrl #(
    .DEPTH(DEPTH)
`ifdef FSC_DEBOUNCE_EN
    , .DEB_CYCLES(4)
`endif
  ) dut (
    .clk(clk), .reset(reset), .in_str(in_str), .in_comp(in_comp), .done(done),
    .submit(submit), .delete(delete), .roll_back(roll_back),
    .str_len(str_len), .last_char(last_char), .full(full), .busy(busy),
    .result_valid(result_valid), .match_cnt(match_cnt), .found(found), .first_pos(first_pos)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int first;
    int fnd;
    int busyCycles;
  } exp_t;

  exp_t       expQ[$];
  logic [3:0] model[$];
  int         vectors = 0;
  int         miscompares = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t modelExpect(input logic [3:0] comp);
    exp_t e;
    e.cnt = 0; e.first = 0; e.fnd = 0;
    e.busyCycles = (model.size() == 0) ? 1 : model.size();
    for (int i = 0; i < model.size(); i++) begin
      if (model[i] == comp) begin
        if (e.fnd == 0) e.first = i;
        e.fnd = 1;
        e.cnt++;
      end
    end
    return e;
  endfunction

  // Press the selected keys together, hold, release and let the sequencer settle.
  task automatic applyStimulus(input bit s, input bit d, input bit r);
    @(posedge clk); #1;
    submit = ~s; delete = ~d; roll_back = ~r;
    repeat (HOLD) @(posedge clk);
    #1;
    submit = 1'b1; delete = 1'b1; roll_back = 1'b1;
    repeat (REL) @(posedge clk);
    #1;
  endtask

  task automatic doSubmit(input logic [3:0] v);
    in_str = v;
    applyStimulus(1'b1, 1'b0, 1'b0);
    if (model.size() < DEPTH) model.push_back(v);
  endtask

  task automatic doDelete();
    applyStimulus(1'b0, 1'b1, 1'b0);
    if (model.size() > 0) void'(model.pop_back());
  endtask

  task automatic doClear();
    applyStimulus(1'b0, 1'b0, 1'b1);
    model.delete();
  endtask

  // Launch a search by raising done (ENTRY) or pressing roll_back (RESULT), then score it.
  task automatic runSearch(input bit viaRollBack, input logic [3:0] comp);
    exp_t e;
    int   busyCnt;
    bit   got;
    expQ.push_back(modelExpect(comp));
    @(posedge clk); #1;
    in_comp = comp;
    if (viaRollBack) roll_back = 1'b0;
    else             done = 1'b1;
    busyCnt = 0;
    got     = 1'b0;
    for (int c = 0; c < 80 && !got; c++) begin
      @(negedge clk);
      if (busy) busyCnt++;
      if (result_valid && busyCnt > 0) got = 1'b1;
    end
    checkOutput("result_seen", got, 1);
    e = expQ.pop_front();
    checkOutput("busy_cycles", busyCnt, e.busyCycles);
    checkOutput("match_cnt", match_cnt, e.cnt);
    checkOutput("found", found, e.fnd);
    checkOutput("first_pos", first_pos, e.first);
    if (viaRollBack) begin
      #1 roll_back = 1'b1;
      repeat (REL) @(posedge clk);
      #1;
    end
  endtask

  task automatic leaveResult();
    done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("left_result_valid", result_valid, 0);
    checkOutput("left_match_cnt", match_cnt, 0);
    checkOutput("left_len", str_len, model.size());
  endtask

  initial begin
    reset = 1'b0; in_str = '0; in_comp = '0; done = 1'b0;
    submit = 1'b1; delete = 1'b1; roll_back = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_len", str_len, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_valid", result_valid, 0);
    checkOutput("rst_match", match_cnt, 0);
    @(posedge clk); #1 reset = 1'b1;

    // Basic entry and search
    doSubmit(4'h3); doSubmit(4'hA); doSubmit(4'h3); doSubmit(4'h5);
    checkOutput("t1_len", str_len, 4);
    checkOutput("t1_last", last_char, 5);
    runSearch(1'b0, 4'h3);
    leaveResult();

    // Fill past full, then delete past empty
    doClear();
    checkOutput("t2_clear_len", str_len, 0);
    for (int i = 0; i < 8; i++) doSubmit(4'h1);
    checkOutput("t2_len8", str_len, 8);
    checkOutput("t2_full", full, 1);
    doSubmit(4'h1);
    checkOutput("t2_len_after_9th", str_len, 8);
    for (int i = 0; i < 8; i++) doDelete();
    checkOutput("t2_len0", str_len, 0);
    doDelete();
    checkOutput("t2_len_after_9th_del", str_len, 0);
    checkOutput("t2_last_empty", last_char, 0);

    // Empty search
    runSearch(1'b0, 4'h0);
    leaveResult();

    // Search then re-search via roll_back
    doSubmit(4'h7); doSubmit(4'h7); doSubmit(4'h2);
    runSearch(1'b0, 4'h2);
    runSearch(1'b1, 4'h7);
    leaveResult();

    // Simultaneous submit+delete
    doClear();
    doSubmit(4'h4); doSubmit(4'h6);
    in_str = 4'h9;
    applyStimulus(1'b1, 1'b1, 1'b0);
    void'(model.pop_back());
    checkOutput("t5_len", str_len, 1);
    checkOutput("t5_last", last_char, 4);

    // Short randomized sweep
    for (int n = 0; n < 3; n++) begin
      int len;
      doClear();
      len = $urandom_range(1, DEPTH);
      for (int i = 0; i < len; i++) doSubmit(4'($urandom_range(0, 3)));
      runSearch(1'b0, 4'($urandom_range(0, 3)));
      leaveResult();
    end

    // Reset in the middle of a search
    doClear();
    doSubmit(4'h4); doSubmit(4'h4); doSubmit(4'h4); doSubmit(4'h4); doSubmit(4'h4); doSubmit(4'h4);
    @(posedge clk); #1;
    in_comp = 4'h4; done = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("t5_busy_before_rst", busy, 1);
    #1 reset = 1'b0;
    #1;
    checkOutput("t5_rst_busy", busy, 0);
    checkOutput("t5_rst_len", str_len, 0);
    checkOutput("t5_rst_match", match_cnt, 0);
    checkOutput("t5_rst_found", found, 0);
    done = 1'b0;
    model.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

`ifdef FSC_DEBOUNCE_EN
    // Glitch rejection and a clean press
    in_str = 4'hB;
    submit = 1'b0;
    repeat (2) @(posedge clk);
    #1 submit = 1'b1;
    repeat (15) @(posedge clk);
    @(negedge clk);
    checkOutput("t6_glitch_len", str_len, 0);
    @(posedge clk); #1 submit = 1'b0;
    repeat (10) @(posedge clk);
    #1 submit = 1'b1;
    repeat (15) @(posedge clk);
    @(negedge clk);
    model.push_back(4'hB);
    checkOutput("t6_clean_len", str_len, 1);
    checkOutput("t6_clean_last", last_char, 4'hB);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
